// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared mode encodings, channel-count bounds and select-width helpers
package demux_pkg;

    localparam logic MODE_UNI   = 1'b0;
    localparam logic MODE_BCAST = 1'b1;

    localparam int NUM_OUT_MIN = 2;
    localparam int NUM_OUT_MAX = 16;

    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A select bus is never narrower than one bit, even for tiny channel counts.
    function automatic int sel_width(input int n);
        return (clog2_f(n) < 1) ? 1 : clog2_f(n);
    endfunction

endpackage

// File: rtl/demux_dec.sv
// rtl/demux_dec.sv - channel decode: one-hot or all-ones target mask plus out-of-range flag
module demux_dec
    import demux_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic               bcast,
    input  logic               en,
    output logic [NUM_OUT-1:0] mask,
    output logic               oob
);

    logic [31:0] sel_ext;

    assign sel_ext = 32'(sel);

    always_comb begin
        mask = '0;
        oob  = 1'b0;
        if (en) begin
            if (bcast == MODE_BCAST) begin
                mask = '1;
            end else if (sel_ext < 32'(NUM_OUT)) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    mask[i] = (sel_ext == 32'(i));
                end
            end else begin
                oob = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_router.sv
// rtl/demux_router.sv - registered 1-to-NUM_OUT demux with unicast/broadcast and per-channel backpressure
module demux_router
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = sel_width(NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               err_oob,
    output logic               busy
);

    logic [NUM_OUT-1:0] pend;
    logic [NUM_OUT-1:0] rem;
    logic [NUM_OUT-1:0] dec_mask;
    logic               dec_oob;
    logic               accept;

    // Ready looks through this cycle's handshakes so a draining word never costs a bubble.
    assign rem       = pend & ~out_ready;
    assign in_ready  = (rem == '0);
    assign accept    = in_valid & in_ready;
    assign out_valid = pend;
    assign busy      = |pend;

    demux_dec #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .sel   (in_sel),
        .bcast (in_bcast),
        .en    (accept),
        .mask  (dec_mask),
        .oob   (dec_oob)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            out_data <= '0;
            err_oob  <= 1'b0;
        end else begin
            err_oob <= dec_oob;
            if (accept) begin
                out_data <= in_data;
                pend     <= dec_mask;
            end else begin
                pend     <= rem;
            end
        end
    end

    a_num_out_range: assert property (@(posedge clk)
        (NUM_OUT >= NUM_OUT_MIN) && (NUM_OUT <= NUM_OUT_MAX));

    a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (|rem) |=> $stable(out_data));

    a_valid_holds: assert property (@(posedge clk) disable iff (!rst_n)
        (|rem) |=> ((out_valid & $past(rem)) == $past(rem)));

endmodule

// File: tb/tb_demux_router.sv
// tb/tb_demux_router.sv - vector table, corner sequences and randomized model check for demux_router
module tb_demux_router;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic       err_oob;
    logic       busy;

    logic       in_valid3;
    logic       in_ready3;
    logic [7:0] in_data3;
    logic [1:0] in_sel3;
    logic       in_bcast3;
    logic [2:0] out_valid3;
    logic [2:0] out_ready3;
    logic [7:0] out_data3;
    logic       err_oob3;
    logic       busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_router #(.DATA_W(8), .NUM_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_oob(err_oob), .busy(busy)
    );

    demux_router #(.DATA_W(8), .NUM_OUT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .in_sel(in_sel3), .in_bcast(in_bcast3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .err_oob(err_oob3), .busy(busy3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic       bc;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [3:0] ev;
        logic [7:0] ed;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [1:0] sel, logic bc, logic [7:0] d, logic [3:0] rdy,
                                logic [3:0] ev, logic [7:0] ed, logic er);
        vec_t r;
        r.v = v; r.sel = sel; r.bc = bc; r.d = d; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.er = er;
        return r;
    endfunction

    // Reference model: each channel either owes the consumer the held word or not.
    bit [3:0]   m_owed;
    logic [7:0] m_data;
    bit         m_err;

    function automatic bit model_ready(input logic [3:0] rdy);
        bit blocked = 1'b0;
        for (int i = 0; i < 4; i++) if (m_owed[i] && !rdy[i]) blocked = 1'b1;
        return !blocked;
    endfunction

    task automatic model_step(input logic v, input logic [1:0] sel, input logic bc,
                              input logic [7:0] d, input logic [3:0] rdy);
        bit can_take;
        can_take = model_ready(rdy);
        for (int i = 0; i < 4; i++) if (m_owed[i] && rdy[i]) m_owed[i] = 1'b0;
        m_err = 1'b0;
        if (v && can_take) begin
            m_data = d;
            if (bc) m_owed = 4'b1111;
            else if (int'(sel) < 4) m_owed[sel] = 1'b1;
            else m_err = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = 0;
        in_valid3 = 0; in_data3 = 0; in_sel3 = 0; in_bcast3 = 0; out_ready3 = 0;
        m_owed = 0; m_data = 0; m_err = 0;

        // Test plan 1, 2, 3 and 5 as per-cycle vectors: outputs expected in the cycle the row is applied.
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b0000, 8'h00, 1));
        tbl.push_back(mk(1, 2, 0, 8'hA5, 4'b1111, 4'b0000, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b0100, 8'hA5, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b0000, 8'hA5, 1));
        tbl.push_back(mk(1, 0, 0, 8'h01, 4'b1111, 4'b0000, 8'hA5, 1));
        tbl.push_back(mk(1, 1, 0, 8'h02, 4'b1111, 4'b0001, 8'h01, 1));
        tbl.push_back(mk(1, 3, 0, 8'h03, 4'b1111, 4'b0010, 8'h02, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b1000, 8'h03, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b0000, 8'h03, 1));
        tbl.push_back(mk(1, 0, 1, 8'h3C, 4'b0000, 4'b0000, 8'h03, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0001, 4'b1111, 8'h3C, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0011, 4'b1110, 8'h3C, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0111, 4'b1100, 8'h3C, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b1000, 8'h3C, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 8'h3C, 1));
        tbl.push_back(mk(1, 1, 0, 8'h55, 4'b0000, 4'b0000, 8'h3C, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 2, 0, 8'h66, 4'b0000, 4'b0010, 8'h55, 0));
        tbl.push_back(mk(1, 2, 0, 8'h66, 4'b0010, 4'b0010, 8'h55, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b0100, 8'h66, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 4'b0000, 8'h66, 1));

        repeat (2) next_cycle();
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_out_valid", {28'd0, out_valid}, 0);
        rst_n = 1'b1;
        next_cycle();

        foreach (tbl[k]) begin
            in_valid = tbl[k].v; in_sel = tbl[k].sel; in_bcast = tbl[k].bc;
            in_data = tbl[k].d; out_ready = tbl[k].rdy;
            #1;
            chk($sformatf("vec%0d_out_valid", k), {28'd0, out_valid}, {28'd0, tbl[k].ev});
            chk($sformatf("vec%0d_out_data", k), {24'd0, out_data}, {24'd0, tbl[k].ed});
            chk($sformatf("vec%0d_in_ready", k), {31'd0, in_ready}, {31'd0, tbl[k].er});
            chk($sformatf("vec%0d_busy", k), {31'd0, busy}, {31'd0, |tbl[k].ev});
            chk($sformatf("vec%0d_err_oob", k), {31'd0, err_oob}, 0);
            next_cycle();
        end
        in_valid = 0; out_ready = 0;

        // Three-channel build: select 3 is out of range and must be dropped with a one-cycle error.
        in_valid3 = 1; in_sel3 = 2'd3; in_data3 = 8'h77; out_ready3 = 3'b111;
        #1;
        chk("oob_in_ready_before", {31'd0, in_ready3}, 1);
        next_cycle();
        in_valid3 = 0;
        #1;
        chk("oob_err_pulse", {31'd0, err_oob3}, 1);
        chk("oob_out_valid", {29'd0, out_valid3}, 0);
        chk("oob_in_ready", {31'd0, in_ready3}, 1);
        chk("oob_busy", {31'd0, busy3}, 0);
        next_cycle();
        chk("oob_err_cleared", {31'd0, err_oob3}, 0);
        chk("oob_out_valid_after", {29'd0, out_valid3}, 0);
        in_valid3 = 1; in_sel3 = 2'd2; in_data3 = 8'h5A;
        next_cycle();
        in_valid3 = 0;
        #1;
        chk("ch3_sel2_out_valid", {29'd0, out_valid3}, 32'b100);
        chk("ch3_sel2_out_data", {24'd0, out_data3}, 32'h5A);
        chk("ch3_sel2_no_err", {31'd0, err_oob3}, 0);
        next_cycle();

        // Asynchronous reset in the middle of a partially delivered broadcast.
        in_valid = 1; in_bcast = 1; in_data = 8'h99; out_ready = 4'b0000;
        next_cycle();
        in_valid = 0; in_bcast = 0; out_ready = 4'b0101;
        next_cycle();
        out_ready = 4'b0000;
        #1;
        chk("mid_out_valid", {28'd0, out_valid}, 32'b1010);
        chk("mid_out_data", {24'd0, out_data}, 32'h99);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {28'd0, out_valid}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_out_data", {24'd0, out_data}, 0);
        chk("arst_err_oob", {31'd0, err_oob}, 0);
        next_cycle();
        rst_n = 1'b1;
        m_owed = 0; m_data = 0; m_err = 0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);
        next_cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_bcast  = ($urandom_range(0, 4) == 0);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            #1;
            chk("rnd_out_valid", {28'd0, out_valid}, {28'd0, m_owed});
            chk("rnd_out_data", {24'd0, out_data}, {24'd0, m_data});
            chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, model_ready(out_ready)});
            chk("rnd_busy", {31'd0, busy}, {31'd0, |m_owed});
            chk("rnd_err_oob", {31'd0, err_oob}, {31'd0, m_err});
            model_step(in_valid, in_sel, in_bcast, in_data, out_ready);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
